// File: rtl/net_abort_fifo.sv
`default_nettype none
// net_abort_fifo: 2^LGFLEN-entry abortable AXIN packet FIFO (rollback / truncate on ABORT).
// Optional NETFIFO_OVERFLOW_DROP_EN: never stall upstream, abort and drop packets that overflow.
module net_abort_fifo #(
  parameter int DW     = 64,
  parameter int LGFLEN = 4,
  parameter int BW     = $clog2(DW/8)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            S_AXIN_VALID,
  output logic            S_AXIN_READY,
  input  logic [DW-1:0]   S_AXIN_DATA,
  input  logic [BW-1:0]   S_AXIN_BYTES,
  input  logic            S_AXIN_LAST,
  input  logic            S_AXIN_ABORT,
  output logic            M_AXIN_VALID,
  input  logic            M_AXIN_READY,
  output logic [DW-1:0]   M_AXIN_DATA,
  output logic [BW-1:0]   M_AXIN_BYTES,
  output logic            M_AXIN_LAST,
  output logic            M_AXIN_ABORT,
`ifdef NETFIFO_OVERFLOW_DROP_EN
  output logic            o_overflow,
`endif
  output logic [LGFLEN:0] o_fill
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam int EW    = DW + BW + 1;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [LGFLEN:0] r_wr_ptr, r_rd_ptr, r_sop_ptr;
  logic            r_in_pkt, r_leaked, r_abort;

  logic [LGFLEN:0] w_fill, w_rd_next, w_one;
  logic [EW-1:0]   w_head;
  logic            w_full, w_m_xfer, w_leak_now, w_abort_req, w_wr_en;
  logic            w_rollback, w_truncate, w_pkt_end;

  assign w_one  = {{LGFLEN{1'b0}}, 1'b1};
  assign w_fill = r_wr_ptr - r_rd_ptr;
  // Fill never exceeds DEPTH, so its MSB alone marks the full state.
  assign w_full = w_fill[LGFLEN];
  assign w_head = r_mem[r_rd_ptr[LGFLEN-1:0]];

  assign M_AXIN_VALID = (w_fill != '0) && !r_abort;
  assign {M_AXIN_LAST, M_AXIN_BYTES, M_AXIN_DATA} = w_head;
  assign M_AXIN_ABORT = r_abort;
  assign o_fill       = w_fill;

  assign w_m_xfer   = M_AXIN_VALID && M_AXIN_READY;
  assign w_rd_next  = w_m_xfer ? (r_rd_ptr + w_one) : r_rd_ptr;
  // The first word of the open packet leaving this cycle counts as already leaked.
  assign w_leak_now = r_leaked || (w_m_xfer && (r_rd_ptr == r_sop_ptr));

`ifdef NETFIFO_OVERFLOW_DROP_EN
  logic r_drop, r_overflow, w_ovf;

  assign S_AXIN_READY = 1'b1;
  assign w_ovf        = S_AXIN_VALID && w_full && !r_drop && !S_AXIN_ABORT;
  assign w_abort_req  = S_AXIN_ABORT || w_ovf;
  assign w_wr_en      = S_AXIN_VALID && !w_full && !S_AXIN_ABORT && !r_drop;
  assign o_overflow   = r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
      if (w_ovf && !S_AXIN_LAST)
        r_drop <= 1'b1;
      else if (r_drop && ((S_AXIN_VALID && S_AXIN_LAST) || S_AXIN_ABORT))
        r_drop <= 1'b0;
    end
  end
`else
  assign S_AXIN_READY = !w_full;
  assign w_abort_req  = S_AXIN_ABORT;
  assign w_wr_en      = S_AXIN_VALID && !w_full && !S_AXIN_ABORT;
`endif

  assign w_rollback = w_abort_req && r_in_pkt && !w_leak_now;
  assign w_truncate = w_abort_req && r_in_pkt && w_leak_now;
  assign w_pkt_end  = w_abort_req || (w_wr_en && S_AXIN_LAST);

  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[LGFLEN-1:0]] <= {S_AXIN_LAST, S_AXIN_BYTES, S_AXIN_DATA};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_sop_ptr <= '0;
      r_in_pkt  <= 1'b0;
      r_leaked  <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;

      if (w_truncate)
        r_wr_ptr <= w_rd_next;
      else if (w_rollback)
        r_wr_ptr <= r_sop_ptr;
      else if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + w_one;

      if (w_wr_en && !r_in_pkt)
        r_sop_ptr <= r_wr_ptr;

      if (w_pkt_end) begin
        r_in_pkt <= 1'b0;
        r_leaked <= 1'b0;
      end else begin
        if (w_wr_en)
          r_in_pkt <= 1'b1;
        r_leaked <= r_in_pkt && w_leak_now;
      end

      // Held abort masks later words until the sink has seen it.
      if (w_truncate)
        r_abort <= 1'b1;
      else if (M_AXIN_READY)
        r_abort <= 1'b0;
    end
  end

endmodule
`default_nettype wire
